// File: rtl/serial_transmit_pkg.sv
// Shared constants and slot helpers for the serial byte link.
// Both the transmitter and receiver-side filter pull IDLE_BYTE from here.
package serial_transmit_pkg;

  localparam int DATA_W    = 8;
  localparam int FRAME_LEN = 9;
  localparam int IDX_W     = $clog2(FRAME_LEN);

  localparam logic FRAME_BIT = 1'b0;

  localparam logic [DATA_W-1:0] IDLE_BYTE_DEF = 8'h00;

  typedef logic [IDX_W-1:0] slot_idx_t;

  localparam slot_idx_t LAST_IDX = slot_idx_t'(FRAME_LEN - 1);

  function automatic slot_idx_t idx_next(slot_idx_t i);
    return (i == LAST_IDX) ? '0 : i + 1'b1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with a separate occupancy counter.
// Read data is the combinational head entry.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [LW-1:0]    cnt;
  logic             wr;
  logic             rd;

  assign full  = (cnt == LW'(DEPTH));
  assign empty = (cnt == '0);
  assign wr    = push && !full;
  assign rd    = pop && !empty;
  assign rdata = mem[rptr];
  assign level = cnt;

  always_ff @(posedge clk) begin
    if (wr) mem[wptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (wr) wptr <= wptr + 1'b1;
      if (rd) rptr <= rptr + 1'b1;
      unique case ({wr, rd})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/serial_transmit.sv
// Byte serialiser: 9-cycle slots of 8 data bits MSB first plus a 0 frame bit.
// Empty slots carry IDLE_BYTE; a FIFO absorbs producer bursts.
module serial_transmit
  import serial_transmit_pkg::*;
#(
  parameter int                DEPTH     = 4,
  parameter logic [DATA_W-1:0] IDLE_BYTE = IDLE_BYTE_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [DATA_W-1:0]          in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic                       txd,
  output logic                       busy,
  output logic                       frame_done,
  output logic [$clog2(DEPTH+1)-1:0] fifo_level
);

  // cnt_q is the slot index the next edge starts, so the
  // frame-bit cycle currently on txd is the one with cnt_q == 0.
  slot_idx_t         cnt_q;
  slot_idx_t         cnt_d;
  logic [DATA_W-1:0] shift_q;
  logic [DATA_W-1:0] shift_d;
  logic              busy_q;
  logic              busy_d;
  logic              txd_q;
  logic              txd_d;
  logic [2:0]        bit_sel;

  logic              load;
  logic              pop;
  logic              push;
  logic [DATA_W-1:0] fifo_rdata;
  logic              fifo_full;
  logic              fifo_empty;

  assign push = in_valid && !fifo_full;
  assign load = (cnt_q == '0);
  assign pop  = load && !fifo_empty;

  sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .wdata (in_data),
    .rdata (fifo_rdata),
    .level (fifo_level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      shift_q <= IDLE_BYTE;
      busy_q  <= 1'b0;
      txd_q   <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      busy_q  <= busy_d;
      txd_q   <= txd_d;
    end
  end

  always_comb begin
    cnt_d   = idx_next(cnt_q);
    shift_d = shift_q;
    busy_d  = busy_q;
    if (load) begin
      shift_d = pop ? fifo_rdata : IDLE_BYTE;
      busy_d  = pop;
    end
  end

  // bit 7-k for slot index k is just the 3-bit complement of k
  assign bit_sel = ~cnt_q[2:0];

  always_comb begin
    txd_d = FRAME_BIT;
    unique case (1'b1)
      (cnt_q == LAST_IDX): txd_d = FRAME_BIT;
      default:             txd_d = shift_d[bit_sel];
    endcase
  end

  assign txd        = txd_q;
  assign busy       = busy_q;
  assign frame_done = busy_q && load;
  assign in_ready   = !fifo_full;

endmodule

// File: tb/tb_serial_transmit.sv
// Randomised and directed bench for serial_transmit against a
// queue-based slot model plus a txd frame reassembler.
module tb_serial_transmit;
  import serial_transmit_pkg::*;

  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH+1);
  localparam logic [7:0] IDLE = IDLE_BYTE_DEF;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          txd;
  logic          busy;
  logic          frame_done;
  logic [LW-1:0] fifo_level;

  int total = 0;
  int bad = 0;

  logic [7:0] q[$];
  logic [7:0] log_q[$];
  logic [7:0] cur;
  logic [7:0] asm_b;
  bit         m_busy;
  bit         started;
  int         m_idx;

  serial_transmit #(
    .DEPTH     (DEPTH),
    .IDLE_BYTE (IDLE)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .txd        (txd),
    .busy       (busy),
    .frame_done (frame_done),
    .fifo_level (fifo_level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    log_q.delete();
    started = 0;
    m_busy  = 0;
    cur     = IDLE;
    m_idx   = 0;
    asm_b   = '0;
  endtask

  function automatic logic exp_txd();
    if (!started) return 1'b1;
    if (m_idx == 8) return 1'b0;
    return cur[7-m_idx];
  endfunction

  task automatic step(input bit v, input logic [7:0] d);
    bit acc;
    logic [7:0] e;
    in_valid = v;
    in_data  = d;
    chk("in_ready", in_ready, q.size() < DEPTH);
    acc = v && (q.size() < DEPTH);
    @(posedge clk);
    if (!started || m_idx == 8) begin
      if (q.size() > 0) begin
        cur = q.pop_front();
        m_busy = 1;
      end else begin
        cur = IDLE;
        m_busy = 0;
      end
    end
    if (acc) begin
      q.push_back(d);
      log_q.push_back(d);
    end
    m_idx   = started ? (m_idx + 1) % 9 : 0;
    started = 1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("txd", txd, exp_txd());
    chk("busy", busy, m_busy);
    chk("frame_done", frame_done, m_busy && m_idx == 8);
    chk("fifo_level", fifo_level, q.size());
    if (m_idx < 8) begin
      asm_b[7-m_idx] = txd;
    end else if (m_busy) begin
      chk("frame_src", log_q.size() > 0, 1);
      if (log_q.size() > 0) begin
        e = log_q.pop_front();
        chk("frame", asm_b, e);
      end
    end
  endtask

  task automatic wait_idx(input int k);
    int n = 0;
    while (m_idx != k && n < 20) begin
      step(0, '0);
      n++;
    end
    chk("wait_idx", m_idx, k);
  endtask

  task automatic push_hold(input logic [7:0] b);
    int n = 0;
    bit ok;
    do begin
      ok = q.size() < DEPTH;
      step(1, b);
      n++;
    end while (!ok && n < 40);
    if (!ok) chk("push_timeout", n, 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, '0);
  endtask

  initial begin
    logic [7:0] r;
    int rate;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_txd", txd, 1);
    chk("rst_busy", busy, 0);
    chk("rst_fd", frame_done, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_ready", in_ready, 1);
    rst_n = 1'b1;

    idle(27);

    wait_idx(0);
    step(1, 8'hA5);
    idle(20);

    wait_idx(0);
    for (int b = 1; b <= 5; b++) push_hold(8'(b));
    idle(60);

    wait_idx(8);
    step(1, 8'h3C);
    idle(30);

    for (int b = 0; b < 8; b++) push_hold(8'h80 + 8'(b));
    idle(80);

    wait_idx(0);
    step(1, 8'h11);
    step(1, 8'h22);
    step(1, 8'h33);
    begin
      int n = 0;
      while (!(m_busy && m_idx == 4) && n < 30) begin
        step(0, '0);
        n++;
      end
      chk("mid_slot_reach", m_busy && m_idx == 4, 1);
    end
    chk("pre_rst_level", fifo_level, 2);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("arst_txd", txd, 1);
    chk("arst_busy", busy, 0);
    chk("arst_level", fifo_level, 0);
    chk("arst_ready", in_ready, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle(30);

    rate = 50;
    for (int i = 0; i < 900; i++) begin
      if (i % 100 == 0) rate = $urandom_range(0, 3) * 33 + 1;
      r = 8'($urandom);
      if ($urandom_range(0, 3) == 0) r = IDLE;
      step($urandom_range(0, 99) < rate, r);
    end
    idle(60);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_transmit.md
Name: serial_transmit

Overview:
- Upstream partner of the serial byte receiver: takes parallel bytes from a producer and serialises them onto the single-bit line `txd` that feeds the receiver's `rxd`.
- Line format is a continuous stream of 9-cycle slots: 8 data bits MSB first, then one frame bit fixed at 0.
- A small FIFO decouples the bursty producer from the fixed slot rate.
- Slots with no queued data carry IDLE_BYTE, which downstream logic discards.

Parameters:
DEPTH, 4, FIFO capacity in bytes (power of two, >= 2).
IDLE_BYTE, 8'h00, fill byte sent in slots with no queued data.

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous, active-low reset
in_data  input  8  byte to transmit
in_valid  input  1  producer offers in_data this cycle
in_ready  output  1  FIFO can accept a byte this cycle
txd  output  1  registered serial line to receiver rxd
busy  output  1  current slot carries a FIFO byte (not idle fill)
frame_done  output  1  one-cycle pulse on last cycle of a data-carrying slot
fifo_level  output  $clog2(DEPTH+1)  bytes currently queued (0..DEPTH)

Behaviour:
- Reset (rst_n low, async):
  - txd=1, busy=0, frame_done=0, fifo_level=0, in_ready=1.
  - FIFO pointers cleared; slot counter = 0; shift register = IDLE_BYTE.
  - Reset mid-slot or mid-burst discards all queued and in-flight data; no partial frame is resumed.
- Slot counter idx runs 0..8 and wraps 8->0 every cycle, free-running from reset release.
- The first rising edge after rst_n deasserts starts slot idx 0 with the initial IDLE_BYTE, so txd goes to IDLE_BYTE[7].
- txd value per slot index:
  - During idx k in 0..7: txd = current_byte[7-k].
  - During idx 8: txd = 0 (frame bit). It is never 1 outside reset.
- Slot load, on the edge leaving idx 8:
  - If the FIFO is non-empty, pop the head into the shift register and set busy=1 for the whole next slot.
  - Otherwise load IDLE_BYTE and set busy=0.
  - A byte whose value equals IDLE_BYTE is still sent with busy=1.
- frame_done = busy && idx==8, combinational from registered state, high exactly one cycle per data slot.
- Push handshake:
  - in_ready = (fifo_level != DEPTH).
  - A push occurs on an edge where in_valid && in_ready.
  - A push when full is impossible; in_data is ignored while in_ready=0.
- Simultaneous push and pop on the same edge:
  - fifo_level is unchanged; pointers both advance.
  - Pop decision uses pre-edge level only, so there is no bypass.
  - A byte pushed into an empty FIFO on the idx-8 edge waits one full slot.
- Latency:
  - Byte pushed into an empty FIFO during idx j reaches txd bit 7 after (9-j) cycles for j in 0..7.
  - Pushed during idx 8, it reaches txd bit 7 after 9 cycles.
- Pointers are log2(DEPTH) bits and wrap naturally; fifo_level is a separate counter, +1 on push only, -1 on pop only.
- Throughput: one byte per 9 cycles sustained; a producer pushing faster fills the FIFO and sees in_ready=0.

Decomposition:
- Shared package:
  - FRAME_LEN=9, DATA_W=8, FRAME_BIT=1'b0.
  - Default IDLE_BYTE, so the receiver-side filter uses the same constant.
- One sub-module: sync_fifo.
  - Parameters WIDTH, DEPTH.
  - Ports: push, pop, wdata, rdata, level, full, empty; same clk/rst_n.
- Slot counter, shift register and output logic stay in serial_transmit.

Test Plan:
- Reset then no input for 27 cycles -> txd shows three slots of 00000000 then 0; busy=0, frame_done never high, fifo_level=0.
- Push 8'hA5 during idx 0 of a slot -> next slot txd = 1,0,1,0,0,1,0,1 then 0; busy=1 for those 9 cycles; frame_done high on the idx-8 cycle only.
- Push 8'h01,8'h02,8'h03,8'h04,8'h05 on consecutive cycles with DEPTH=4:
  - in_ready drops after 4 accepted pushes while the FIFO is full; 8'h05 is held until a pop.
  - Bytes appear on txd in order 01..05 in back-to-back slots; fifo_level traces 1,2,3,4 then decrements at each slot boundary.
- Push on the idx-8 edge into an empty FIFO -> the following slot is IDLE, the byte is sent one slot later, and fifo_level is 1 during the wait.
- FIFO full, then push on the same edge as a pop (in_ready high only after the pop) -> level stays consistent, no byte lost or duplicated, order preserved.
- Assert rst_n low at idx 4 of a data slot with 2 bytes queued -> txd=1 immediately (async); after release a fresh idle slot starts at idx 0, fifo_level=0, and neither queued byte is ever sent.
